// File: rtl/instruction_cache.sv
// instruction_cache
//   Direct-mapped, read-only instruction cache. Serves the fetch port with a
//   combinational hit/instruction lookup and refills a missing line from the
//   memory controller one 32-bit word at a time over a req/done handshake.
//
// Ports
//   clockIn   - clock
//   resetIn   - synchronous active-high reset (valid bits, FSM, memReq/memAddr)
//   readyIn   - global run enable; all state holds while low
//   fetchIn   - fetch byte address (bits [1:0] ignored)
//   hit       - fetchIn is resident, insOut valid this cycle
//   insOut    - instruction word at fetchIn
//   memReq    - registered word read request
//   memAddr   - registered word-aligned request address
//   memDone   - one-cycle completion pulse, memData valid with it
//   memData   - returned word
module instruction_cache #(
    parameter int INDEX_WIDTH = 6,
    parameter int BLOCK_WIDTH = 2
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic [31:0] fetchIn,
    output logic        hit,
    output logic [31:0] insOut,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memDone,
    input  logic [31:0] memData
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - BLOCK_WIDTH - 2;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << BLOCK_WIDTH;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state;

    logic [BLOCK_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;

    assign offset = fetchIn[BLOCK_WIDTH+1:2];
    assign index  = fetchIn[INDEX_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2];
    assign tag    = fetchIn[31:INDEX_WIDTH+BLOCK_WIDTH+2];

    // byte-within-word bits have no meaning for a word-wide fetch port
    logic unusedByteBits;
    assign unusedByteBits = ^fetchIn[1:0];

    logic [LINES-1:0]       valid;
    logic [TAG_WIDTH-1:0]   tags [LINES];
    logic [31:0]            data [LINES*WORDS];   // addressed as {index, offset}

    logic [INDEX_WIDTH-1:0] fillIndex;
    logic [TAG_WIDTH-1:0]   fillTag;
    logic [BLOCK_WIDTH-1:0] count;
    logic                   lastWord;
    logic                   fillWrite;

    // The line under fill has its valid bit cleared at fill start, so it
    // reads as a miss until the last word lands.
    assign hit    = ~resetIn & valid[index] & (tags[index] == tag);
    assign insOut = data[{index, offset}];

    assign lastWord  = (count == BLOCK_WIDTH'(WORDS - 1));
    assign fillWrite = ~resetIn & readyIn & (state == FILL) & memDone;

    // Data and tag arrays are never reset; the valid bits guard them.
    always_ff @(posedge clockIn) begin
        if (fillWrite) begin
            data[{fillIndex, count}] <= memData;
            if (lastWord)
                tags[fillIndex] <= fillTag;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            state   <= IDLE;
            valid   <= '0;
            memReq  <= 1'b0;
            memAddr <= '0;
            count   <= '0;
        end else if (readyIn) begin
            case (state)
                IDLE: begin
                    // memDone seen here is stray and ignored
                    if (!hit) begin
                        fillIndex    <= index;
                        fillTag      <= tag;
                        valid[index] <= 1'b0;
                        memReq       <= 1'b1;
                        memAddr      <= {fetchIn[31:BLOCK_WIDTH+2], {(BLOCK_WIDTH+2){1'b0}}};
                        count        <= '0;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    // fill runs to completion regardless of fetchIn
                    if (memDone) begin
                        if (lastWord) begin
                            valid[fillIndex] <= 1'b1;
                            memReq           <= 1'b0;
                            state            <= IDLE;
                        end else begin
                            count   <= count + 1'b1;
                            memAddr <= memAddr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;
    logic        clockIn = 1'b0;
    logic        resetIn, readyIn, memDone, hit, memReq;
    logic [31:0] fetchIn, insOut, memAddr, memData;

    always #5 clockIn = ~clockIn;

    instruction_cache dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .fetchIn(fetchIn),
        .hit(hit), .insOut(insOut), .memReq(memReq), .memAddr(memAddr),
        .memDone(memDone), .memData(memData)
    );

    int total = 0, bad = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // reference model: which line base is resident per index, plus the
    // queue of word addresses still owed by the fill in progress
    bit          mRes [64];
    logic [21:0] mTag [64];
    bit          busy, addrZero, expHit;
    int          fillIdx;
    logic [21:0] fillTag;
    logic [31:0] q[$];

    // memory responder
    int          age, lat, fixLat, doneCnt;
    bit          junk, consumed, reqPrev, readyPrev, rstPrev;
    logic [31:0] doneAddrs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic settle();
        if (resetIn)
            memDone = 1'b0;
        else if (readyIn && memReq && age >= lat - 1) begin
            memDone = 1'b1;
            memData = memWord(memAddr);
        end else if (junk && (!memReq || !readyIn) && $urandom_range(0, 3) == 0) begin
            memDone = 1'b1;
            memData = $urandom;
        end else
            memDone = 1'b0;
        #1;
        expHit = !resetIn && mRes[fetchIn[9:4]] && mTag[fetchIn[9:4]] == fetchIn[31:10];
        chk("hit", hit, expHit);
        if (expHit) chk("insOut", insOut, memWord({fetchIn[31:2], 2'b00}));
        chk("memReq", memReq, busy);
        if (busy) chk("memAddr", memAddr, q[0]);
        else if (addrZero) chk("memAddrAfterReset", memAddr, 32'h0);
    endtask

    task automatic advance();
        consumed = !resetIn && readyIn && memReq && memDone;
        if (consumed) begin
            doneCnt++;
            doneAddrs.push_back(memAddr);
        end
        if (resetIn) begin
            foreach (mRes[i]) mRes[i] = 1'b0;
            busy = 1'b0; q.delete(); addrZero = 1'b1;
        end else if (readyIn) begin
            if (!busy) begin
                if (!expHit) begin
                    fillIdx = int'(fetchIn[9:4]);
                    fillTag = fetchIn[31:10];
                    mRes[fillIdx] = 1'b0;
                    for (int k = 0; k < 4; k++) q.push_back({fetchIn[31:4], 4'h0} + 32'(4 * k));
                    busy = 1'b1; addrZero = 1'b0;
                end
            end else if (memDone) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    mRes[fillIdx] = 1'b1; mTag[fillIdx] = fillTag; busy = 1'b0;
                end
            end
        end
        reqPrev = memReq; readyPrev = readyIn; rstPrev = resetIn;
        @(posedge clockIn); #1;
        if (rstPrev) age = 0;
        else if (readyPrev) begin
            if (consumed || !reqPrev) begin
                age = 0;
                lat = (fixLat != 0) ? fixLat : int'($urandom_range(1, 3));
            end else age++;
        end
    endtask

    task automatic cyc(input logic [31:0] f, input bit r, input bit rs);
        fetchIn = f; readyIn = r; resetIn = rs;
        settle();
        advance();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (memReq === 1'b1 && n < 200) begin cyc(fetchIn, 1'b1, 1'b0); n++; end
        chk(name, memReq, 1'b0);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (doneCnt < target && n < 60) begin cyc(fetchIn, 1'b1, 1'b0); n++; end
        chk(name, doneCnt >= target, 1'b1);
    endtask

    typedef struct {
        logic [31:0] fetch;
        bit          ready;
        bit          eHit;
        bit          eReq;
        bit          chkAddr;
        logic [31:0] eAddr;
        logic [31:0] eIns;
    } vec_t;
    vec_t tbl[$];

    initial begin
        // cold miss on 0x0, 2-cycle memory, one stall cycle, then hits
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0});
        tbl.push_back('{32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC, 32'h0});
        tbl.push_back('{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_0000});
        tbl.push_back('{32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_000C});
        tbl.push_back('{32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5_0008});

        resetIn = 1'b1; readyIn = 1'b1; fetchIn = 32'h0; memDone = 1'b0; memData = 32'h0;
        @(posedge clockIn); #1;
        foreach (mRes[i]) mRes[i] = 1'b0;
        busy = 1'b0; addrZero = 1'b1; age = 0; fixLat = 2; lat = 2; junk = 1'b0; doneCnt = 0;
        cyc(32'h0, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            fetchIn = tbl[i].fetch; readyIn = tbl[i].ready; resetIn = 1'b0;
            settle();
            chk("tblHit", hit, tbl[i].eHit);
            chk("tblReq", memReq, tbl[i].eReq);
            if (tbl[i].chkAddr) chk("tblAddr", memAddr, tbl[i].eAddr);
            if (tbl[i].eHit) chk("tblIns", insOut, tbl[i].eIns);
            advance();
        end

        // conflict eviction: 0x400 shares index 0 with 0x0
        cyc(32'h400, 1'b1, 1'b0);
        chk("evictAddr", memAddr, 32'h400);
        wait_idle("evictFillEnd");
        fetchIn = 32'h0; settle();
        chk("evictMiss", hit, 1'b0);
        advance();
        chk("refillReq", memReq, 1'b1);
        chk("refillAddr", memAddr, 32'h0);
        wait_idle("refillEnd");

        // fetch address change after the 2nd word
        cyc(32'h100, 1'b1, 1'b0);
        doneAddrs.delete();
        wait_done(doneCnt + 2, "midFillTwoWords");
        fetchIn = 32'h200;
        wait_idle("midFillEnd");
        chk("midFillWords", doneAddrs.size(), 4);
        if (doneAddrs.size() == 4) begin
            chk("midFillW2", doneAddrs[2], 32'h108);
            chk("midFillW3", doneAddrs[3], 32'h10C);
        end
        cyc(32'h200, 1'b1, 1'b0);
        chk("newFillAddr", memAddr, 32'h200);
        fetchIn = 32'h100; settle();
        chk("line100Valid", hit, 1'b1);
        advance();
        wait_idle("fill200End");

        // hit on another line during a fill
        cyc(32'h40, 1'b1, 1'b0);
        fetchIn = 32'h4; settle();
        chk("hitDuringFill", hit, 1'b1);
        chk("insDuringFill", insOut, 32'hA5A5_0004);
        advance();
        fetchIn = 32'h44; settle();
        chk("fillingLineMiss", hit, 1'b0);
        advance();
        wait_idle("fill40End");
        fetchIn = 32'h44; settle();
        chk("line40Valid", hit, 1'b1);
        advance();

        // readyIn stall mid-fill
        cyc(32'h80, 1'b1, 1'b0);
        cyc(32'h80, 1'b1, 1'b0);
        cyc(32'h80, 1'b1, 1'b0);
        begin
            logic        r0;
            logic [31:0] a0;
            r0 = memReq; a0 = memAddr;
            for (int s = 0; s < 5; s++) begin
                cyc(32'h80, 1'b0, 1'b0);
                chk("stallReq", memReq, r0);
                chk("stallAddr", memAddr, a0);
            end
        end
        readyIn = 1'b1;
        wait_idle("stallFillEnd");
        fetchIn = 32'h8C; settle();
        chk("stallHit", hit, 1'b1);
        chk("stallIns", insOut, 32'hA5A5_008C);
        advance();

        // reset after the 2nd word of a fill
        cyc(32'hC0, 1'b1, 1'b0);
        wait_done(doneCnt + 2, "rstTwoWords");
        cyc(32'hC0, 1'b1, 1'b1);
        chk("rstReq", memReq, 1'b0);
        chk("rstAddr", memAddr, 32'h0);
        begin
            logic [31:0] sweep [6];
            sweep = '{32'h0, 32'h4, 32'h40, 32'h100, 32'h400, 32'hC0};
            foreach (sweep[i]) begin
                fetchIn = sweep[i]; readyIn = 1'b0; resetIn = 1'b0;
                settle();
                chk("rstAllMiss", hit, 1'b0);
                advance();
            end
        end

        // randomized traffic against the model
        junk = 1'b1; fixLat = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] f;
            f = fetchIn;
            if ($urandom_range(0, 1) == 0)
                f = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                    (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            cyc(f, $urandom_range(0, 9) != 0, $urandom_range(0, 299) == 0);
        end
        junk = 1'b0;
        wait_idle("finalDrain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
